ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
// PURPOSE
//  Decodes the PS/2 scan-code byte stream into key press and release events.
//  Handles the E0 (extended) and F0 (break) prefixes and tracks the most recently held key.
//  Counts presses with a parametrised counter and buffers press events in a FIFO for a consumer.
//  Sits between ps2_keyboard and the display/ASCII logic. Replaces raw scan_code counting.
// PARAMETERS
//  CNT_W  8  width of the press counter; wraps modulo 2^CNT_W
//  DEPTH  8  press-event FIFO depth in entries; must be a power of 2 and >= 2
// PORTS
//  clk         in   1      system clock; all logic on posedge
//  rst         in   1      reset, synchronous, active-high
//  code_valid  in   1      one-cycle strobe: code holds a new scan-code byte
//  code        in   8      scan-code byte from ps2_keyboard
//  key_down    out  1      1 while the tracked key is held
//  held_ext    out  1      tracked key is an E0-extended key
//  held_code   out  8      make code of the tracked key
//  press_cnt   out  CNT_W  number of accepted presses
//  ev_empty    out  1      FIFO empty
//  ev_data     out  9      FIFO head {ext, code}; first-word fall-through, valid when !ev_empty
//  ev_rd       in   1      pop the head this cycle; ignored when ev_empty
//  ev_ovf      out  1      sticky: a press was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (rst=1 at posedge): all outputs 0, ev_empty=1, FSM=IDLE, FIFO pointers 0. A code_valid in the same cycle is ignored.
//  Prefix FSM advances only on code_valid. All other bytes are complete codes.
//   IDLE:    E0->EXT; F0->BRK; other->PRESS(ext=0), stay IDLE
//   EXT:     F0->EXT_BRK; E0->EXT; other->PRESS(ext=1), ->IDLE
//   BRK:     E0->EXT_BRK; F0->BRK; other->RELEASE(ext=0), ->IDLE
//   EXT_BRK: E0/F0 -> stay; other->RELEASE(ext=1), ->IDLE
//  Codes 0x00, 0xAA and 0xFA are device responses. They create no event and return the FSM to IDLE.
//  PRESS (accepted) at posedge N:
//   - key_down=1, held_ext/held_code updated at N+1
//   - press_cnt+1 at N+1; wraps from 2^CNT_W-1 to 0
//   - {ext,code} pushed to the FIFO; ev_empty falls at N+1 if it was empty
//  RELEASE: if {ext,code} == {held_ext,held_code} and key_down=1, key_down=0 at N+1.
//   held_code/held_ext keep their value. Any other release is ignored.
//  FIFO: push on PRESS, pop on ev_rd & !ev_empty.
//   - Full and push without pop: entry dropped, ev_ovf=1 until rst.
//   - Full and push with pop in the same cycle: both take effect, no drop.
//   - Empty and push with ev_rd: push only; ev_rd is ignored.
//   - Pointers are ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)). Full/empty are decided by the MSB compare.
// CONFIGURATION
//  TYPEMATIC_FILTER_EN defined:
//   - A PRESS whose {ext,code} equals the held key while key_down=1 is an auto-repeat.
//   - An auto-repeat is discarded: no count, no push, no state change.
//  TYPEMATIC_FILTER_EN undefined: every PRESS is accepted, including auto-repeats.
// TESTING
//  T1 reset: drive rst for 2 cycles mid-stream (after E0) -> all outputs 0, ev_empty=1.
//     Next byte 1C -> PRESS ext=0, not ext=1.
//  T2 basic: 1C, F0 1C -> press_cnt=1, ev_data=0x01C, key_down 1 then 0.
//     ev_rd -> ev_empty=1.
//  T3 extended: E0 75, E0 F0 75 -> ev_data=0x175, held_ext=1, key_down=0 after the break.
//     Stray F0 1C afterwards -> no change.
//  T4 repeat: 1C x5, F0 1C -> press_cnt=5 and 5 entries without the macro.
//     With TYPEMATIC_FILTER_EN: press_cnt=1, 1 entry.
//  T5 overflow: DEPTH+1 distinct presses, no reads -> ev_ovf=1 and the first DEPTH codes read back in order.
//     Full plus simultaneous push/pop -> no drop.
//  T6 wrap: CNT_W=4, 17 presses -> press_cnt=1.
//     Device bytes AA/FA between presses -> no events.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Turns the PS/2 scan-code byte stream into key press/release events.
//   E0 (extended) and F0 (break) prefixes are folded into a small prefix FSM,
//   the most recently pressed key is tracked, presses are counted, and press
//   events are queued in a first-word fall-through FIFO for a consumer.
//
// Parameters
//   CNT_W  width of the press counter (wraps modulo 2**CNT_W)
//   DEPTH  press-event FIFO depth, power of 2, >= 2
//
// Ports
//   clk         system clock, posedge
//   rst         synchronous active-high reset
//   code_valid  one-cycle strobe qualifying code
//   code        scan-code byte
//   key_down    tracked key currently held
//   held_ext    tracked key is E0-extended
//   held_code   make code of tracked key
//   press_cnt   accepted press count
//   ev_empty    FIFO empty
//   ev_data     FIFO head {ext, code}, valid when !ev_empty (0 when empty)
//   ev_rd       pop head; ignored when empty
//   ev_ovf      sticky: a press was dropped on a full FIFO
//
// Configuration
//   TYPEMATIC_FILTER_EN  when defined, a press of the already-held key
//                        (auto-repeat) is discarded entirely.

module ps2_key_tracker #(
   parameter int CNT_W = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             code_valid,
   input  logic [7:0]       code,
   output logic             key_down,
   output logic             held_ext,
   output logic [7:0]       held_code,
   output logic [CNT_W-1:0] press_cnt,
   output logic             ev_empty,
   output logic [8:0]       ev_data,
   input  logic             ev_rd,
   output logic             ev_ovf
);

   localparam int ADDR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK
   } state_t;

   state_t             r_state;
   logic               r_key_down;
   logic               r_held_ext;
   logic [7:0]         r_held_code;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ovf;
   logic [8:0]         r_mem [DEPTH];
   logic [ADDR_W:0]    r_wptr;
   logic [ADDR_W:0]    r_rptr;

   logic               w_is_e0;
   logic               w_is_f0;
   logic               w_is_dev;
   logic               w_press;
   logic               w_release;
   logic               w_ev_ext;
   logic               w_match;
   logic               w_accept;
   logic               w_rel_hit;
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push;

   assign w_is_e0  = (code == 8'hE0);
   assign w_is_f0  = (code == 8'hF0);
   assign w_is_dev = (code == 8'h00) || (code == 8'hAA) || (code == 8'hFA);

   // Event classification: only a complete (non-prefix, non-device) byte
   // produces an event; its kind comes from the prefix state.
   always_comb begin
      w_press   = 1'b0;
      w_release = 1'b0;
      w_ev_ext  = 1'b0;
      if (code_valid && !w_is_dev && !w_is_e0 && !w_is_f0) begin
         unique case (r_state)
            S_IDLE:    begin w_press   = 1'b1; w_ev_ext = 1'b0; end
            S_EXT:     begin w_press   = 1'b1; w_ev_ext = 1'b1; end
            S_BRK:     begin w_release = 1'b1; w_ev_ext = 1'b0; end
            S_EXT_BRK: begin w_release = 1'b1; w_ev_ext = 1'b1; end
            default:   begin w_press   = 1'b0; w_release = 1'b0; end
         endcase
      end
   end

   assign w_match = r_key_down && ({w_ev_ext, code} == {r_held_ext, r_held_code});

`ifdef TYPEMATIC_FILTER_EN
   assign w_accept = w_press && !w_match;
`else
   assign w_accept = w_press;
`endif

   assign w_rel_hit = w_release && w_match;

   // Pointers carry one extra wrap bit: equal low bits with differing MSB is full.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                    (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
   assign w_pop   = ev_rd && !w_empty;
   // A pop in the same cycle frees the slot the push needs.
   assign w_push  = w_accept && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_key_down  <= 1'b0;
         r_held_ext  <= 1'b0;
         r_held_code <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_wptr      <= '0;
         r_rptr      <= '0;
      end else begin
         if (code_valid) begin
            if (w_is_dev) begin
               r_state <= S_IDLE;
            end else if (w_is_e0) begin
               unique case (r_state)
                  S_IDLE:    r_state <= S_EXT;
                  S_EXT:     r_state <= S_EXT;
                  S_BRK:     r_state <= S_EXT_BRK;
                  S_EXT_BRK: r_state <= S_EXT_BRK;
                  default:   r_state <= S_IDLE;
               endcase
            end else if (w_is_f0) begin
               unique case (r_state)
                  S_IDLE:    r_state <= S_BRK;
                  S_EXT:     r_state <= S_EXT_BRK;
                  S_BRK:     r_state <= S_BRK;
                  S_EXT_BRK: r_state <= S_EXT_BRK;
                  default:   r_state <= S_IDLE;
               endcase
            end else begin
               r_state <= S_IDLE;
            end
         end

         if (w_accept) begin
            r_key_down  <= 1'b1;
            r_held_ext  <= w_ev_ext;
            r_held_code <= code;
            r_cnt       <= r_cnt + 1'b1;
         end else if (w_rel_hit) begin
            r_key_down  <= 1'b0;
         end

         if (w_accept && w_full && !w_pop)
            r_ovf <= 1'b1;
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_push)
         r_mem[r_wptr[ADDR_W-1:0]] <= {w_ev_ext, code};
   end

   assign key_down  = r_key_down;
   assign held_ext  = r_held_ext;
   assign held_code = r_held_code;
   assign press_cnt = r_cnt;
   assign ev_empty  = w_empty;
   assign ev_data   = w_empty ? '0 : r_mem[r_rptr[ADDR_W-1:0]];
   assign ev_ovf    = r_ovf;

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

   localparam int CNT_W = 4;
   localparam int DEPTH = 8;
`ifdef TYPEMATIC_FILTER_EN
   localparam int T4_CNT = 1;
`else
   localparam int T4_CNT = 5;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             code_valid = 1'b0;
   logic [7:0]       code = '0;
   logic             key_down;
   logic             held_ext;
   logic [7:0]       held_code;
   logic [CNT_W-1:0] press_cnt;
   logic             ev_empty;
   logic [8:0]       ev_data;
   logic             ev_rd = 1'b0;
   logic             ev_ovf;

   ps2_key_tracker #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .code_valid (code_valid),
      .code       (code),
      .key_down   (key_down),
      .held_ext   (held_ext),
      .held_code  (held_code),
      .press_cnt  (press_cnt),
      .ev_empty   (ev_empty),
      .ev_data    (ev_data),
      .ev_rd      (ev_rd),
      .ev_ovf     (ev_ovf)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   // Reference model: prefixes are just two "seen" flags cleared by any
   // complete byte or device response.
   bit           m_ext_seen, m_brk_seen;
   bit           m_kd, m_hext, m_ovf;
   int unsigned  m_hcode, m_cnt;
   logic [8:0]   m_q[$];

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_ext_seen = 0; m_brk_seen = 0;
      m_kd = 0; m_hext = 0; m_ovf = 0;
      m_hcode = 0; m_cnt = 0;
      m_q.delete();
   endtask

   task automatic model_cycle(input bit valid, input logic [7:0] b, input bit rd);
      bit pop, push;
      bit rep, acc;
      pop  = rd && (m_q.size() > 0);
      push = 0;
      if (valid) begin
         if (b == 8'h00 || b == 8'hAA || b == 8'hFA) begin
            m_ext_seen = 0; m_brk_seen = 0;
         end else if (b == 8'hE0) begin
            m_ext_seen = 1;
         end else if (b == 8'hF0) begin
            m_brk_seen = 1;
         end else begin
            rep = m_kd && (m_hext == m_ext_seen) && (m_hcode == b);
            if (!m_brk_seen) begin
`ifdef TYPEMATIC_FILTER_EN
               acc = !rep;
`else
               acc = 1;
`endif
               if (acc) begin
                  m_kd = 1; m_hext = m_ext_seen; m_hcode = b;
                  m_cnt = (m_cnt + 1) % (1 << CNT_W);
                  push = 1;
               end
            end else if (rep) begin
               m_kd = 0;
            end
            if (push) begin
               if (pop) void'(m_q.pop_front());
               pop = 0;
               if (m_q.size() < DEPTH) m_q.push_back({m_ext_seen, b});
               else m_ovf = 1;
            end
            m_ext_seen = 0; m_brk_seen = 0;
         end
      end
      if (pop) void'(m_q.pop_front());
   endtask

   task automatic compare_all();
      check("key_down",  key_down,  m_kd);
      check("held_ext",  held_ext,  m_hext);
      check("held_code", held_code, m_hcode);
      check("press_cnt", press_cnt, m_cnt);
      check("ev_empty",  ev_empty,  (m_q.size() == 0));
      check("ev_data",   ev_data,   (m_q.size() > 0) ? m_q[0] : 9'h000);
      check("ev_ovf",    ev_ovf,    m_ovf);
   endtask

   task automatic step(input bit valid, input logic [7:0] b, input bit rd);
      @(negedge clk);
      code_valid = valid; code = b; ev_rd = rd;
      @(posedge clk);
      model_cycle(valid, b, rd);
      #1;
      code_valid = 1'b0; ev_rd = 1'b0;
      compare_all();
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b1, b, 1'b0);
   endtask

   task automatic do_reset(input int unsigned n);
      @(negedge clk);
      rst = 1'b1; code_valid = 1'b1; code = 8'h1C; ev_rd = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0; code_valid = 1'b0; ev_rd = 1'b0;
      model_clear();
      compare_all();
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      logic [7:0] keys [4];
      int unsigned r;
      logic [7:0] b;
      keys[0] = 8'h1C; keys[1] = 8'h75; keys[2] = 8'h12; keys[3] = 8'h6B;
      model_clear();

      // T1: reset mid-stream after E0
      do_reset(2);
      send(8'h1C);
      send(8'hE0);
      do_reset(2);
      check("t1_rst_empty", ev_empty, 1);
      check("t1_rst_kd", key_down, 0);
      send(8'h1C);
      check("t1_ext0_press", ev_data, 9'h01C);

      // T2: basic press/release/read
      do_reset(1);
      send(8'h1C);
      check("t2_kd_up", key_down, 1);
      send(8'hF0); send(8'h1C);
      check("t2_cnt", press_cnt, 1);
      check("t2_data", ev_data, 9'h01C);
      check("t2_kd_down", key_down, 0);
      step(1'b0, 8'h00, 1'b1);
      check("t2_empty", ev_empty, 1);

      // T3: extended press/release, stray break
      send(8'hE0); send(8'h75);
      check("t3_data", ev_data, 9'h175);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("t3_hext", held_ext, 1);
      check("t3_kd", key_down, 0);
      send(8'hF0); send(8'h1C);
      check("t3_hcode", held_code, 8'h75);
      drain();

      // T4: auto-repeat
      do_reset(1);
      repeat (5) send(8'h1C);
      send(8'hF0); send(8'h1C);
      check("t4_cnt", press_cnt, T4_CNT);
      drain();

      // T5: overflow then in-order readback
      do_reset(1);
      for (int i = 0; i < DEPTH + 1; i++) send(8'h10 + 8'(i));
      check("t5_ovf", ev_ovf, 1);
      for (int i = 0; i < DEPTH; i++) begin
         check("t5_order", ev_data, 9'h010 + 9'(i));
         step(1'b0, 8'h00, 1'b1);
      end
      // full plus simultaneous push/pop: nothing dropped
      do_reset(1);
      for (int i = 0; i < DEPTH; i++) send(8'h20 + 8'(i));
      step(1'b1, 8'h30, 1'b1);
      check("t5_nodrop_ovf", ev_ovf, 0);
      for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1);
      check("t5_last", ev_data, 9'h030);
      drain();

      // T6: counter wrap with device bytes interleaved
      do_reset(1);
      for (int i = 0; i < 17; i++) begin
         send(8'h40 + 8'(i));
         send((i % 2 == 0) ? 8'hAA : 8'hFA);
      end
      check("t6_wrap", press_cnt, 1);
      send(8'hE0); send(8'h00); send(8'h12);
      check("t6_dev_clears_ext", held_ext, 0);

      // Randomized stream against the model
      do_reset(1);
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 15);
         if (r < 2) b = 8'hE0;
         else if (r < 5) b = 8'hF0;
         else if (r == 5) begin
            r = $urandom_range(0, 2);
            b = (r == 0) ? 8'h00 : ((r == 1) ? 8'hAA : 8'hFA);
         end else b = keys[$urandom_range(0, 3)];
         if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 2));
         else step($urandom_range(0, 9) < 8, b, $urandom_range(0, 9) < 3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
